// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
package muldiv_pkg;

  // M-extension func3 encodings
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  // Width of the iteration counter for a given operand width
  function automatic int unsigned cnt_w(input int unsigned xlen);
    return $clog2(xlen);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface ex_muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      func3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            busy;
  logic            result_valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, func3, op_a, op_b, flush,
    input  busy, result_valid, result
  );

  modport slave (
    input  start, func3, op_a, op_b, flush,
    output busy, result_valid, result
  );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Operand magnitude extraction and final sign correction for the
// multiply/divide unit. Purely combinational.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]        func3,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic [XLEN-1:0]   mag_a,
  output logic [XLEN-1:0]   mag_b,
  output logic              sign_diff,
  output logic              a_neg,
  input  logic [2*XLEN-1:0] prod_in,
  input  logic [XLEN-1:0]   quo_in,
  input  logic [XLEN-1:0]   rem_in,
  input  logic              neg_ab,
  input  logic              neg_a,
  output logic [2*XLEN-1:0] prod_out,
  output logic [XLEN-1:0]   quo_out,
  output logic [XLEN-1:0]   rem_out
);

  logic a_signed;
  logic b_signed;
  logic b_neg;

  // Decide operand signedness and take magnitudes
  always_comb begin
    a_signed  = (func3 == F3_MUL) || (func3 == F3_MULH) || (func3 == F3_MULHSU) ||
                (func3 == F3_DIV) || (func3 == F3_REM);
    b_signed  = (func3 == F3_MUL) || (func3 == F3_MULH) ||
                (func3 == F3_DIV) || (func3 == F3_REM);
    a_neg     = a_signed & op_a[XLEN-1];
    b_neg     = b_signed & op_b[XLEN-1];
    mag_a     = a_neg ? -op_a : op_a;
    mag_b     = b_neg ? -op_b : op_b;
    sign_diff = a_neg ^ b_neg;
  end

  // Restore the sign of the unsigned core results
  always_comb begin
    prod_out = neg_ab ? -prod_in : prod_in;
    quo_out  = neg_ab ? -quo_in  : quo_in;
    rem_out  = neg_a  ? -rem_in  : rem_in;
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring
// divider sharing one 2*XLEN accumulator, one iteration per cycle.
// Optional build macro: MULDIV_ZERO_SKIP_EN (zero-operand multiplies
// complete on the fast path).
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic             clk,
  input logic             rst_n,
  ex_muldiv_unit_if.slave bus
);

  localparam int unsigned CW = cnt_w(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        func3_q, func3_d;
  logic [XLEN-1:0]   mag_a_q, mag_a_d;
  logic [XLEN-1:0]   mag_b_q, mag_b_d;
  logic              neg_ab_q, neg_ab_d;
  logic              neg_a_q, neg_a_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [XLEN-1:0]   mag_a_in, mag_b_in;
  logic              sign_diff_in, a_neg_in;
  logic [XLEN-1:0]   addend;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN-1:0]   final_res;
  logic              fast_hit;
  logic [XLEN-1:0]   fast_res;

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .func3     (bus.func3),
    .op_a      (bus.op_a),
    .op_b      (bus.op_b),
    .mag_a     (mag_a_in),
    .mag_b     (mag_b_in),
    .sign_diff (sign_diff_in),
    .a_neg     (a_neg_in),
    .prod_in   (acc_step),
    .quo_in    (acc_step[XLEN-1:0]),
    .rem_in    (acc_step[2*XLEN-1:XLEN]),
    .neg_ab    (neg_ab_q),
    .neg_a     (neg_a_q),
    .prod_out  (prod_fix),
    .quo_out   (quo_fix),
    .rem_out   (rem_fix)
  );

  // One datapath step: multiply keeps {hi, multiplier}, divide keeps {rem, quo}
  always_comb begin
    addend    = acc_q[0] ? mag_a_q : '0;
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, addend};
    div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, mag_b_q};
    if (func3_q[2]) begin
      if (!div_trial[XLEN]) begin
        acc_step = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_step = {acc_q[2*XLEN-2:0], 1'b0};
      end
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // Result selection from the sign-corrected core outputs
  always_comb begin
    unique case (func3_q)
      F3_MUL:                        final_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  final_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               final_res = quo_fix;
      F3_REM, F3_REMU:               final_res = rem_fix;
      default:                       final_res = '0;
    endcase
  end

  // Cases resolved at accept time without iterating
  always_comb begin
    fast_hit = 1'b0;
    fast_res = '0;
    if (bus.func3[2]) begin
      if (bus.op_b == '0) begin
        fast_hit = 1'b1;
        fast_res = bus.func3[1] ? bus.op_a : '1;
      end else if (!bus.func3[0] && (bus.op_a == MOST_NEG) && (bus.op_b == '1)) begin
        fast_hit = 1'b1;
        fast_res = bus.func3[1] ? '0 : bus.op_a;
      end
    end
`ifdef MULDIV_ZERO_SKIP_EN
    else if ((bus.op_a == '0) || (bus.op_b == '0)) begin
      fast_hit = 1'b1;
      fast_res = '0;
    end
`endif
  end

  // Control FSM; result is registered on the edge entering DONE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    func3_d  = func3_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    neg_ab_d = neg_ab_q;
    neg_a_d  = neg_a_q;
    acc_d    = acc_q;
    result_d = result_q;
    valid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          func3_d  = bus.func3;
          mag_a_d  = mag_a_in;
          mag_b_d  = mag_b_in;
          neg_ab_d = sign_diff_in;
          neg_a_d  = a_neg_in;
          cnt_d    = '0;
          acc_d    = bus.func3[2] ? {{XLEN{1'b0}}, mag_a_in} : {{XLEN{1'b0}}, mag_b_in};
          if (fast_hit) begin
            result_d = fast_res;
            valid_d  = 1'b1;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) begin
            result_d = final_res;
            valid_d  = 1'b1;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      func3_q  <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      neg_ab_q <= 1'b0;
      neg_a_q  <= 1'b0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      func3_q  <= func3_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      neg_ab_q <= neg_ab_d;
      neg_a_q  <= neg_a_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.result_valid = valid_q;
  assign bus.result       = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit (XLEN=32).
module tb_ex_muldiv_unit;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ex_muldiv_unit_if #(.XLEN(XLEN)) bus ();

  ex_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: RV32M semantics from plain wide arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint          ub = longint'({32'd0, b});
    longint unsigned uua = {32'd0, a};
    longint unsigned uub = {32'd0, b};
    logic [63:0]     p;
    case (f3)
      3'd0: begin p = uua * uub; return p[31:0]; end
      3'd1: begin p = sa * sb;   return p[63:32]; end
      3'd2: begin p = sa * ub;   return p[63:32]; end
      3'd3: begin p = uua * uub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == MINV && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    if (f3 >= 3'd4 && b == 32'd0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == MINV && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_ZERO_SKIP_EN
    if (f3 < 3'd4 && (a == 32'd0 || b == 32'd0)) return 1;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return MINV;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation and watch 40 cycles: latency, result, busy, pulse count
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string nm);
    int          vcyc = -1;
    int          npulse = 0;
    int          busy_bad = 0;
    logic [31:0] got = '0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.func3 = f3;
    bus.op_a  = a;
    bus.op_b  = b;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      if (bus.result_valid === 1'b1) begin
        npulse++;
        if (vcyc < 0) begin
          vcyc = c;
          got  = bus.result;
        end
      end
      if (c <= lat + 2 && bus.busy !== (c <= lat)) busy_bad++;
    end
    chk({nm, "_lat"},    64'(vcyc),     64'(lat));
    chk({nm, "_res"},    64'(got),      64'(exp));
    chk({nm, "_busy"},   64'(busy_bad), 64'd0);
    chk({nm, "_pulses"}, 64'(npulse),   64'd1);
  endtask

  initial begin
    int          vcyc;
    int          npulse;
    logic [31:0] got;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;

    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.func3 = '0;
    bus.op_a  = '0;
    bus.op_b  = '0;

    vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
    vecs.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33});
    vecs.push_back('{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33});
    vecs.push_back('{3'd5, 32'd100,        32'd7,         32'd14,        33});
    vecs.push_back('{3'd7, 32'd100,        32'd7,         32'd2,         33});
    vecs.push_back('{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{3'd7, 32'd5,          32'd0,         32'd5,         1});
    vecs.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1});
    vecs.push_back('{3'd4, 32'd7,          32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{3'd6, 32'h8000_0000,  32'd0,         32'h8000_0000, 1});
`ifdef MULDIV_ZERO_SKIP_EN
    vecs.push_back('{3'd0, 32'd0,          32'h1234,      32'd0,         1});
`else
    vecs.push_back('{3'd0, 32'd0,          32'h1234,      32'd0,         33});
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy",   64'(bus.busy),         64'd0);
    chk("rst_valid",  64'(bus.result_valid), 64'd0);
    chk("rst_result", 64'(bus.result),       64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    foreach (vecs[i]) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
             $sformatf("vec%0d", i));
    end

    // start pulsed in cycle 5 must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.func3 = 3'd0; bus.op_a = 32'd7; bus.op_b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    vcyc = -1; npulse = 0; got = '0;
    for (int c = 1; c <= 45; c++) begin
      if (c > 1) @(negedge clk);
      if (bus.result_valid === 1'b1) begin
        npulse++;
        if (vcyc < 0) begin vcyc = c; got = bus.result; end
      end
      if (c == 5) begin
        bus.start = 1'b1; bus.func3 = 3'd3; bus.op_a = '1; bus.op_b = '1;
      end else begin
        bus.start = 1'b0;
      end
    end
    chk("busy_start_lat",    64'(vcyc),   64'd33);
    chk("busy_start_res",    64'(got),    64'd21);
    chk("busy_start_pulses", 64'(npulse), 64'd1);

    // flush in cycle 10
    @(negedge clk);
    bus.start = 1'b1; bus.func3 = 3'd0; bus.op_a = 32'd7; bus.op_b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    npulse = 0;
    for (int c = 1; c <= 45; c++) begin
      if (c > 1) @(negedge clk);
      if (bus.result_valid === 1'b1) npulse++;
      if (c == 10) bus.flush = 1'b1;
      if (c == 11) begin
        bus.flush = 1'b0;
        chk("flush_busy", 64'(bus.busy), 64'd0);
      end
    end
    chk("flush_pulses", 64'(npulse),     64'd0);
    chk("flush_result", 64'(bus.result), 64'd21);

    // flush together with start in IDLE
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.func3 = 3'd5; bus.op_a = 32'd9; bus.op_b = 32'd0;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_start_busy", 64'(bus.busy), 64'd0);
    npulse = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.result_valid === 1'b1) npulse++;
    end
    chk("flush_start_pulses", 64'(npulse),     64'd0);
    chk("flush_start_result", 64'(bus.result), 64'd21);

    // asynchronous reset in cycle 20
    @(negedge clk);
    bus.start = 1'b1; bus.func3 = 3'd5; bus.op_a = 32'd100; bus.op_b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    chk("mid_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy",   64'(bus.busy),         64'd0);
    chk("arst_valid",  64'(bus.result_valid), 64'd0);
    chk("arst_result", 64'(bus.result),       64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    npulse = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.result_valid === 1'b1) npulse++;
    end
    chk("arst_pulses", 64'(npulse), 64'd0);

    // Randomised operations against the reference model
    for (int n = 0; n < 40; n++) begin
      f3 = 3'($urandom % 8);
      a  = pick();
      b  = pick();
      run_op(f3, a, b, ref_res(f3, a, b), ref_lat(f3, a, b), $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
